// File: rtl/game_control_pkg.sv
// Shared definitions for the game frame sequencer: state encodings, strobe
// constants and the state-to-strobe decode used by the controller.
package game_control_pkg;

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_IDLE       = 4'd1,
    S_GEN_MOVE   = 4'd2,
    S_CHECK      = 4'd3,
    S_APPLY_LINK = 4'd4,
    S_MOVE_EN    = 4'd5,
    S_DRAW_MAP   = 4'd6,
    S_DRAW_LINK  = 4'd7,
    S_DRAW_EN    = 4'd8
  } state_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int NUM_STROBES = 9;

  // Bit order: {init, idle, gen_move, check_collide, apply_act_link,
  //             move_enemies, draw_map, draw_link, draw_enemies}
  function automatic logic [NUM_STROBES-1:0] strobe_decode(input state_t s);
    logic [NUM_STROBES-1:0] v;
    v = '0;
    case (s)
      S_INIT:       v = 9'b1_0000_0000;
      S_IDLE:       v = 9'b0_1000_0000;
      S_GEN_MOVE:   v = 9'b0_0100_0000;
      S_CHECK:      v = 9'b0_0010_0000;
      S_APPLY_LINK: v = 9'b0_0001_0000;
      S_MOVE_EN:    v = 9'b0_0000_1000;
      S_DRAW_MAP:   v = 9'b0_0000_0100;
      S_DRAW_LINK:  v = 9'b0_0000_0010;
      S_DRAW_EN:    v = 9'b0_0000_0001;
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/game_control_phase_timer.sv
// Per-phase watchdog: down-counter reloaded to TIMEOUT-1 on clear, flags
// terminal count once TIMEOUT cycles have elapsed in the phase.
module phase_timer #(
  parameter int             W       = 20,
  parameter logic [W-1:0]   TIMEOUT = 20'd100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1'b1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= RELOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/game_control.sv
// Frame sequencer for the game datapath: walks the per-frame phases on the
// datapath done handshakes, with watchdog, pause and frame counting.
module game_control
  import game_control_pkg::*;
#(
  parameter int          INIT_CYCLES = 4,
  parameter logic [19:0] TIMEOUT     = 20'd100000,
  parameter int          FRAME_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pause,
  input  logic               idle_done,
  input  logic               check_collide_done,
  input  logic               draw_map_done,
  input  logic               draw_link_done,
  input  logic               draw_enemies_done,
  output logic               init,
  output logic               idle,
  output logic               gen_move,
  output logic               check_collide,
  output logic               apply_act_link,
  output logic               move_enemies,
  output logic               draw_map,
  output logic               draw_link,
  output logic               draw_enemies,
  output logic [FRAME_W-1:0] frame_count,
  output logic               timeout_err,
  output logic [3:0]         state_dbg
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES);

  state_t                 state, next_state, succ;
  logic                   arm;
  logic [IW-1:0]          init_cnt;
  logic [NUM_STROBES-1:0] strobe_q;
  logic                   timer_en, timer_clr, tc;
  logic                   done_ok, timed_out;

  phase_timer #(.W(20), .TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .tc     (tc)
  );

  // Wait states ignore done during their arm (first) cycle so a done left
  // high by the previous phase cannot cause an early or double advance.
  always_comb begin
    next_state = state;
    succ       = state;
    timer_en   = 1'b0;
    done_ok    = 1'b0;
    case (state)
      S_INIT:       if (init_cnt == INIT_LAST) next_state = S_IDLE;
      S_IDLE: begin
        succ     = S_GEN_MOVE;
        timer_en = !pause;
        done_ok  = idle_done && !pause;
      end
      S_GEN_MOVE:   next_state = S_CHECK;
      S_CHECK: begin
        succ     = S_APPLY_LINK;
        timer_en = 1'b1;
        done_ok  = !arm && check_collide_done;
      end
      S_APPLY_LINK: next_state = S_MOVE_EN;
      S_MOVE_EN:    next_state = S_DRAW_MAP;
      S_DRAW_MAP: begin
        succ     = S_DRAW_LINK;
        timer_en = 1'b1;
        done_ok  = !arm && draw_map_done;
      end
      S_DRAW_LINK: begin
        succ     = S_DRAW_EN;
        timer_en = 1'b1;
        done_ok  = !arm && draw_link_done;
      end
      S_DRAW_EN: begin
        succ     = S_IDLE;
        timer_en = 1'b1;
        done_ok  = !arm && draw_enemies_done;
      end
      default:      next_state = S_INIT;
    endcase
    timed_out = timer_en && tc && !done_ok;
    if (done_ok || timed_out) next_state = succ;
    // Paused idle is exempt from the watchdog, so it gets a fresh window on release.
    timer_clr = (next_state != state) || ((state == S_IDLE) && pause);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_INIT;
      arm         <= 1'b1;
      init_cnt    <= '0;
      strobe_q    <= '0;
      frame_count <= '0;
      timeout_err <= OFF;
    end else begin
      state    <= next_state;
      arm      <= (next_state != state);
      init_cnt <= ((state == S_INIT) && (next_state == S_INIT)) ? init_cnt + 1'b1 : '0;
      strobe_q <= strobe_decode(next_state);
      if (timed_out) timeout_err <= ON;
      if ((state == S_DRAW_EN) && (next_state == S_IDLE)) frame_count <= frame_count + 1'b1;
    end
  end

  assign {init, idle, gen_move, check_collide, apply_act_link,
          move_enemies, draw_map, draw_link, draw_enemies} = strobe_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: a per-cycle vector table for one normal
// frame, then hand sequences for arm masking, pause, watchdog and reset.
module tb_game_control;
  import game_control_pkg::*;

  logic        clock = 1'b0;
  logic        reset, pause, idle_done;
  logic        check_collide_done, draw_map_done, draw_link_done, draw_enemies_done;
  logic        init, idle, gen_move, check_collide, apply_act_link;
  logic        move_enemies, draw_map, draw_link, draw_enemies;
  logic [15:0] frame_count;
  logic        timeout_err;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  game_control #(.INIT_CYCLES(4), .TIMEOUT(20'd16), .FRAME_W(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .pause              (pause),
    .idle_done          (idle_done),
    .check_collide_done (check_collide_done),
    .draw_map_done      (draw_map_done),
    .draw_link_done     (draw_link_done),
    .draw_enemies_done  (draw_enemies_done),
    .init               (init),
    .idle               (idle),
    .gen_move           (gen_move),
    .check_collide      (check_collide),
    .apply_act_link     (apply_act_link),
    .move_enemies       (move_enemies),
    .draw_map           (draw_map),
    .draw_link          (draw_link),
    .draw_enemies       (draw_enemies),
    .frame_count        (frame_count),
    .timeout_err        (timeout_err),
    .state_dbg          (state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       p, id, cd, md, ld, ed;
    logic [3:0] st;
    int         fc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [8:0] onehot(input logic [3:0] st);
    logic [8:0] top;
    top = 9'b1_0000_0000;
    return top >> st;
  endfunction

  function automatic logic [8:0] strobes();
    return {init, idle, gen_move, check_collide, apply_act_link,
            move_enemies, draw_map, draw_link, draw_enemies};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_state(input string name, input logic [3:0] st);
    check({name, "_state"}, 32'(state_dbg), 32'(st));
    check({name, "_strobe"}, 32'(strobes()), 32'(onehot(st)));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic p, id, cd, md, ld, ed);
    pause = p; idle_done = id; check_collide_done = cd;
    draw_map_done = md; draw_link_done = ld; draw_enemies_done = ed;
  endtask

  task automatic add(input int n, input logic p, id, cd, md, ld, ed,
                     input logic [3:0] st, input int fc);
    vec_t v;
    v.p = p; v.id = id; v.cd = cd; v.md = md; v.ld = ld; v.ed = ed;
    v.st = st; v.fc = fc;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic wait_state(input string name, input logic [3:0] st, input int limit);
    int n;
    n = 0;
    while (state_dbg !== st && n < limit) begin
      step();
      n++;
    end
    check({name, "_reached"}, 32'(state_dbg), 32'(st));
  endtask

  initial begin
    int bad;
    int cnt;

    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_strobes", 32'(strobes()), 0);
      check("rst_state", 32'(state_dbg), 32'(S_INIT));
      check("rst_frame", 32'(frame_count), 0);
      check("rst_err", 32'(timeout_err), 0);
    end
    reset = 1'b0;

    // One normal frame: collide +5, map +10, link +3, enemies +3.
    add(4, 1,0,0,0,0,0, S_INIT,       0);
    add(1, 1,0,0,0,0,0, S_IDLE,       0);
    add(1, 1,1,0,0,0,0, S_IDLE,       0);
    add(1, 0,1,0,0,0,0, S_GEN_MOVE,   0);
    add(1, 0,0,0,0,0,0, S_CHECK,      0);
    add(4, 0,0,0,0,0,0, S_CHECK,      0);
    add(1, 0,0,1,0,0,0, S_APPLY_LINK, 0);
    add(1, 0,0,0,0,0,0, S_MOVE_EN,    0);
    add(1, 0,0,0,0,0,0, S_DRAW_MAP,   0);
    add(9, 0,0,0,0,0,0, S_DRAW_MAP,   0);
    add(1, 0,0,0,1,0,0, S_DRAW_LINK,  0);
    add(2, 0,0,0,0,0,0, S_DRAW_LINK,  0);
    add(1, 0,0,0,0,1,0, S_DRAW_EN,    0);
    add(2, 0,0,0,0,0,0, S_DRAW_EN,    0);
    add(1, 1,0,0,0,0,1, S_IDLE,       1);

    foreach (vq[i]) begin
      drive(vq[i].p, vq[i].id, vq[i].cd, vq[i].md, vq[i].ld, vq[i].ed);
      step();
      expect_state($sformatf("vec%0d", i), vq[i].st);
      check($sformatf("vec%0d_frame", i), 32'(frame_count), 32'(vq[i].fc));
      check($sformatf("vec%0d_err", i), 32'(timeout_err), 0);
    end

    // Dones held high across phase entry: arm cycle masks, each wait lasts 2 cycles.
    drive(0, 1, 0, 0, 0, 0);
    step(); expect_state("a_gen", S_GEN_MOVE);
    drive(0, 0, 1, 1, 0, 0);
    step(); expect_state("a_chk0", S_CHECK);
    step(); expect_state("a_chk1", S_CHECK);
    step(); expect_state("a_apply", S_APPLY_LINK);
    step(); expect_state("a_moveen", S_MOVE_EN);
    step(); expect_state("a_map0", S_DRAW_MAP);
    step(); expect_state("a_map1", S_DRAW_MAP);
    drive(0, 0, 0, 1, 1, 1);
    step(); expect_state("a_link0", S_DRAW_LINK);
    drive(0, 0, 0, 0, 1, 1);
    step(); expect_state("a_link1", S_DRAW_LINK);
    step(); expect_state("a_en0", S_DRAW_EN);
    step(); expect_state("a_en1", S_DRAW_EN);
    drive(1, 0, 0, 0, 0, 1);
    step(); expect_state("a_idle", S_IDLE);
    check("a_frame", 32'(frame_count), 2);
    drive(1, 0, 0, 0, 0, 0);

    // Pause holds idle across idle_done ticks.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      idle_done = ((i % 7) == 0);
      step();
      if (state_dbg !== S_IDLE) bad++;
    end
    check("pause_hold", 32'(bad), 0);
    check("pause_frame", 32'(frame_count), 2);
    drive(0, 0, 0, 0, 0, 0);
    step(); expect_state("unpause_wait", S_IDLE);
    idle_done = 1'b1;
    step(); expect_state("unpause_tick", S_GEN_MOVE);
    check("unpause_err", 32'(timeout_err), 0);

    // Watchdog: draw_link_done never arrives.
    drive(0, 0, 1, 1, 0, 0);
    wait_state("c_link", S_DRAW_LINK, 20);
    drive(0, 0, 0, 0, 0, 0);
    cnt = 1;
    bad = 0;
    while (state_dbg === S_DRAW_LINK && cnt < 40) begin
      if (timeout_err !== 1'b0) bad++;
      step();
      if (state_dbg === S_DRAW_LINK) cnt++;
    end
    check("wd_cycles", 32'(cnt), 16);
    check("wd_early_err", 32'(bad), 0);
    expect_state("wd_next", S_DRAW_EN);
    check("wd_err_set", 32'(timeout_err), 1);
    draw_enemies_done = 1'b1;
    wait_state("wd_idle", S_IDLE, 10);
    drive(1, 0, 0, 0, 0, 0);
    check("wd_frame", 32'(frame_count), 3);
    step();
    check("wd_err_sticky", 32'(timeout_err), 1);

    // Reset asserted while in S_DRAW_EN.
    drive(0, 1, 1, 1, 1, 0);
    wait_state("d_en", S_DRAW_EN, 20);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 1);
    step();
    check("d_state", 32'(state_dbg), 32'(S_INIT));
    check("d_enemies", 32'(draw_enemies), 0);
    check("d_strobes", 32'(strobes()), 0);
    check("d_frame", 32'(frame_count), 0);
    check("d_err", 32'(timeout_err), 0);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    step(); expect_state("d_reinit", S_INIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
